// File: rtl/cmos_pkg.sv
// Shared constants for the OV7670-style stream generator: default timing,
// pattern encodings, FSM state codes and the colour-bar palette.
package cmos_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_BLANK_DEF  = 144;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BACK_DEF   = 17;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_SOLID = 2'd2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    logic [15:0] rgb;
    case (idx)
      3'd0:    rgb = BAR_WHITE;
      3'd1:    rgb = BAR_YELLOW;
      3'd2:    rgb = BAR_CYAN;
      3'd3:    rgb = BAR_GREEN;
      3'd4:    rgb = BAR_MAGENTA;
      3'd5:    rgb = BAR_RED;
      3'd6:    rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/cmos_pclk_gen.sv
// Free-running pixel-clock divider; tick_o marks the sysclk cycle whose
// closing edge drives pclk 1->0, the only moment stream outputs may change.
module cmos_pclk_gen #(
  parameter int PCLK_HALF = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic pclk_o,
  output logic tick_o
);

  localparam int DW = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_HALF - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pclk_q, pclk_d;
  logic          wrap;

  always_comb begin
    wrap   = (div_q == DIV_LAST);
    div_d  = wrap ? '0 : div_q + 1'b1;
    pclk_d = wrap ? ~pclk_q : pclk_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      pclk_q <= pclk_d;
    end
  end

  assign pclk_o = pclk_q;
  assign tick_o = wrap & pclk_q;

endmodule

// File: rtl/cmos_stream_gen.sv
// Camera-side pixel stream source: frame FSM, byte/line counters and test
// pattern mux, all stepped once per falling pclk edge.
module cmos_stream_gen
  import cmos_pkg::*;
#(
  parameter int PCLK_HALF = 2,
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_BLANK   = H_BLANK_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF
) (
  input  logic        sysclk,
  input  logic        sysrst,
  input  logic        en,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_rgb,
  output logic        cmos_pclk,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_db,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int LINE_T = 2 * (H_ACTIVE + H_BLANK);
  localparam int BC_W   = $clog2(LINE_T);
  localparam int V_M1   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int V_M2   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX  = (V_M1 > V_M2) ? V_M1 : V_M2;
  localparam int LC_W   = (V_MAX > 1) ? $clog2(V_MAX + 1) : 1;
  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BPW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(LINE_T - 1);
  localparam logic [BC_W-1:0] BC_HREF   = BC_W'(2 * H_ACTIVE);
  localparam logic [BPW-1:0]  BAR_LAST  = BPW'(BAR_W - 1);

  logic tick;

  cmos_pclk_gen #(
    .PCLK_HALF (PCLK_HALF)
  ) u_pclk (
    .clk_i   (sysclk),
    .rst_n_i (sysrst),
    .pclk_o  (cmos_pclk),
    .tick_o  (tick)
  );

  logic [2:0]      state_q, state_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [LC_W-1:0] lc_q, lc_d;
  logic [1:0]      pat_q, pat_d;
  logic [15:0]     solid_q, solid_d;
  logic [15:0]     fc_q, fc_d;
  logic            start_q, start_d;
  logic [BPW-1:0]  bar_px_q, bar_px_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      db_q, db_d;

  logic            line_end;
  logic            lc_last;
  logic [4:0]      grad_x;
  logic [5:0]      grad_y;
  logic [15:0]     pix;

  always_comb begin
    case (state_q)
      ST_VSYNC:  lc_last = (lc_q == LC_W'(V_SYNC - 1));
      ST_VBACK:  lc_last = (lc_q == LC_W'(V_BACK - 1));
      ST_ACTIVE: lc_last = (lc_q == LC_W'(V_ACTIVE - 1));
      ST_VFRONT: lc_last = (lc_q == LC_W'(V_FRONT - 1));
      default:   lc_last = 1'b0;
    endcase
    line_end = (bc_q == BC_LAST);
  end

  // Counters and state describe the byte slot that the outputs currently hold.
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    lc_d    = lc_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    fc_d    = fc_q;
    start_d = 1'b0;
    if (tick) begin
      if (state_q == ST_IDLE) begin
        bc_d = '0;
        lc_d = '0;
        if (en) begin
          state_d = ST_VSYNC;
          pat_d   = pattern;
          solid_d = solid_rgb;
          start_d = 1'b1;
        end
      end else begin
        bc_d = line_end ? '0 : bc_q + 1'b1;
        if (line_end) begin
          if (lc_last) begin
            lc_d = '0;
            case (state_q)
              ST_VSYNC:  state_d = ST_VBACK;
              ST_VBACK:  state_d = ST_ACTIVE;
              ST_ACTIVE: state_d = ST_VFRONT;
              default: begin
                fc_d = fc_q + 16'd1;
                if (en) begin
                  state_d = ST_VSYNC;
                  pat_d   = pattern;
                  solid_d = solid_rgb;
                  start_d = 1'b1;
                end else begin
                  state_d = ST_IDLE;
                end
              end
            endcase
          end else begin
            lc_d = lc_q + 1'b1;
          end
        end
      end
    end
  end

  // Bar position advances by counting pixels rather than dividing x.
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (tick) begin
      if (bc_d == '0) begin
        bar_px_d  = '0;
        bar_idx_d = '0;
      end else if (bc_q[0]) begin
        if (bar_px_q == BAR_LAST) begin
          bar_px_d  = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_px_d = bar_px_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    grad_x = 5'(bc_d >> 5);
    grad_y = 6'(lc_d >> 3);
    case (pat_d)
      PAT_BARS: pix = bar_rgb(bar_idx_d);
      PAT_GRAD: pix = {grad_x, grad_y, fc_q[4:0]};
      default:  pix = solid_d;
    endcase
    vsync_d = vsync_q;
    href_d  = href_q;
    db_d    = db_q;
    if (tick) begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && (bc_d < BC_HREF);
      if (!href_d) begin
        db_d = 8'h00;
      end else begin
        db_d = bc_d[0] ? pix[7:0] : pix[15:8];
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!sysrst) begin
      state_q   <= ST_IDLE;
      bc_q      <= '0;
      lc_q      <= '0;
      pat_q     <= PAT_BARS;
      solid_q   <= '0;
      fc_q      <= '0;
      start_q   <= 1'b0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      db_q      <= 8'h00;
    end else begin
      state_q   <= state_d;
      bc_q      <= bc_d;
      lc_q      <= lc_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      fc_q      <= fc_d;
      start_q   <= start_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      db_q      <= db_d;
    end
  end

  assign cmos_vsync  = vsync_q;
  assign cmos_href   = href_q;
  assign cmos_db     = db_q;
  assign frame_start = start_q;
  assign frame_count = fc_q;

endmodule

// File: doc/cmos_stream_gen.md
Name: cmos_stream_gen

Overview:
- Synthesizable OV7670-style pixel-stream transmitter: drives cmos_pclk, cmos_vsync, cmos_href and cmos_db exactly as the camera does, and is the counterpart of camera_read.
- Used in place of the real sensor to bring up and regress the camera_read -> pixel_downsample -> BRAM -> VGA path, on the bench and on board.
- Emits RGB565, high byte first, using VGA 640x480 frame timing and a selectable test pattern.

Parameters:
- PCLK_HALF, 2: sysclk cycles per cmos_pclk half-period; ≥1; default gives 25 MHz from 100 MHz.
- H_ACTIVE, 640: active pixels per line; multiple of 8.
- H_BLANK, 144: blank pixels per line, after active region.
- V_SYNC, 3: lines with vsync high.
- V_BACK, 17: blank lines after vsync.
- V_ACTIVE, 480: active lines.
- V_FRONT, 10: blank lines after active region.

Ports:
- sysclk  in  1  system clock
- sysrst  in  1  synchronous reset, active-low
- en  in  1  generate frames while high
- pattern  in  2  0=colour bars, 1=gradient, 2/3=solid
- solid_rgb  in  16  RGB565 value for solid pattern
- cmos_pclk  out  1  generated pixel clock
- cmos_vsync  out  1  frame sync, active high
- cmos_href  out  1  line valid, active high
- cmos_db  out  8  pixel byte
- frame_start  out  1  one-sysclk pulse at vsync rise
- frame_count  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (sysrst=0 at a sysclk edge): cmos_pclk=0, vsync=0, href=0, db=0, frame_start=0, frame_count=0, divider=0, state IDLE.
- Pclk divider:
  - cmos_pclk toggles every PCLK_HALF sysclk cycles whenever out of reset, including in IDLE.
  - "tick" = the sysclk cycle in which cmos_pclk is driven 1->0.
  - vsync, href and db change only on ticks, registered together with the falling pclk edge, so they are stable at every pclk rise.
- Unit of line time: 1 line = LINE_T = 2*(H_ACTIVE+H_BLANK) ticks.
- Byte counter: bc counts 0..LINE_T-1 and wraps.
- Line counter: lc counts lines within the current state.
- States and transitions:
  - IDLE: all stream outputs 0. On a tick with en=1: go to VSYNC, latch pattern and solid_rgb, pulse frame_start, reset bc and lc to 0.
  - VSYNC: vsync=1 for V_SYNC lines, then go to VBACK.
  - VBACK: vsync=0 for V_BACK lines, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines, then go to VFRONT.
    - href=1 for bc in 0..2*H_ACTIVE-1, 0 otherwise.
    - x = bc>>1, y = lc.
    - Even bc: db = pix[15:8]. Odd bc: db = pix[7:0].
    - href low: db = 0.
  - VFRONT: V_FRONT lines. At the end: frame_count += 1. Then go to VSYNC if en=1 (new frame_start; pattern re-latched), else IDLE.
- en deasserted mid-frame: current frame completes normally, then IDLE. en is ignored except in IDLE and at the end of VFRONT.
- Pattern is latched per frame; changes mid-frame have no effect.
- Colour bars:
  - bar index 0..7 advances every H_ACTIVE/8 pixels, using a counter (no divider).
  - Values: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Gradient: pix = {x[8:4], y[8:3], frame_count[4:0]}.
- Solid: pix = latched solid_rgb.
- Frame length = (V_SYNC+V_BACK+V_ACTIVE+V_FRONT)*LINE_T ticks. Default = 510*1568 = 799680.
- Timing is exact: no gaps or extra bytes. Exactly 2*H_ACTIVE href-high pclk rises per active line.

Decomposition:
- Shared package cmos_pkg holds:
  - default timing constants (H_ACTIVE .. V_FRONT);
  - the 8 colour-bar RGB565 constants;
  - the pattern encoding localparams;
  - the state enum encodings.
- Sub-module cmos_pclk_gen: divider producing cmos_pclk and the tick strobe.
- FSM, counters and pattern mux live in cmos_stream_gen.

Test Plan:
Bench parameters unless noted: PCLK_HALF=1, H_ACTIVE=8, H_BLANK=2, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1. This gives LINE_T=20 and 100 ticks per frame.
- Reset: hold sysrst=0 for 5 cycles with en=1 -> all outputs 0, frame_count=0. After release, cmos_pclk period = 2 sysclk.
- Frame timing: en=1, pattern=2, solid_rgb=16'hA5C3, run 3 frames:
  - vsync high for 20 pclk per frame;
  - href high 16 pclk per active line, 2 lines per frame;
  - frame_start pulses exactly 100 pclk apart;
  - frame_count=3.
- Byte order: same run -> bytes sampled at pclk rise while href=1 alternate A5, C3. db=00 while href=0.
- Colour bars: pattern=0 -> active line sampled as FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00.
- en drop: deassert en during active line 1 -> frame completes. No further vsync. frame_count increments once. Outputs remain 0 in IDLE.
- Mid-frame reset: sysrst=0 during href -> next cycle all outputs 0. Restart after release yields a full correct frame.
